pc_sequencer: RTL and testbench

Program-counter sequencer for the single-cycle core. It owns the PC register, drives the 5-bit index into the branch-target LUT and applies the returned signed offset on taken branches. It sequences start, run and halt for the top level and tells instruction fetch when the PC is valid. It sits between the decoder (branch/halt requests) and instruction memory (PC consumer).

---
 rtl/pc_sequencer_pkg.sv | 17 +
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pcseq_sat_counter.sv | 26 ++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared types and default widths for the PC sequencer.
//   pcseq_state_t : sequencer state (IDLE, RUN, BRANCH, HALT)
//   PCSEQ_D       : default PC / LUT target width
//   PCSEQ_LUT_AW  : default branch-target LUT index width
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BRANCH,
        HALT
    } pcseq_state_t;

    localparam int unsigned PCSEQ_D      = 12;
    localparam int unsigned PCSEQ_LUT_AW = 5;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder / LUT / fetch signals around the PC sequencer.
//   master : environment side (decoder requests, LUT data in; PC/status out)
//     start, stall, br_req, br_cond, br_idx, halt, lut_target -> sequencer
//     lut_idx, pc, fetch_valid, done                          <- sequencer
//   slave  : the sequencer itself (directions reversed)
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned D      = PCSEQ_D,
    parameter int unsigned LUT_AW = PCSEQ_LUT_AW
);

    logic              start;
    logic              stall;
    logic              br_req;
    logic              br_cond;
    logic [LUT_AW-1:0] br_idx;
    logic              halt;
    logic [D-1:0]      lut_target;
    logic [LUT_AW-1:0] lut_idx;
    logic [D-1:0]      pc;
    logic              fetch_valid;
    logic              done;

    modport master (
        output start, stall, br_req, br_cond, br_idx, halt, lut_target,
        input  lut_idx, pc, fetch_valid, done
    );

    modport slave (
        input  start, stall, br_req, br_cond, br_idx, halt, lut_target,
        output lut_idx, pc, fetch_valid, done
    );

endinterface

// File: rtl/pcseq_sat_counter.sv
// pcseq_sat_counter: W-bit up counter that sticks at all-ones.
//   clk, reset : clock, asynchronous active-high reset (count -> 0)
//   clr        : synchronous clear, wins over inc
//   inc        : count up by one unless already saturated
//   count      : current value
module pcseq_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the single-cycle core.
// Owns the PC, issues the branch-target LUT index on a taken branch and adds
// the returned signed offset during a one-cycle BRANCH bubble.
//   clk, reset         : clock, asynchronous active-high reset
//   bus (slave)        : start/stall/br_req/br_cond/br_idx/halt/lut_target in,
//                        lut_idx/pc/fetch_valid/done out
//   instr_count[31:0]  : RUN cycles without stall (PC_SEQUENCER_PERF_EN only)
//   taken_count[15:0]  : BRANCH entries          (PC_SEQUENCER_PERF_EN only)
// Optional feature macro: PC_SEQUENCER_PERF_EN (adds saturating perf counters).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned D        = PCSEQ_D,
    parameter int unsigned LUT_AW   = PCSEQ_LUT_AW,
    parameter int unsigned START_PC = 0
) (
    input  logic        clk,
    input  logic        reset,
    pc_sequencer_if.slave bus
`ifdef PC_SEQUENCER_PERF_EN
    ,
    output logic [31:0] instr_count,
    output logic [15:0] taken_count
`endif
);

    pcseq_state_t      state;
    logic [D-1:0]      pc_q;
    logic [LUT_AW-1:0] lut_idx_q;
    logic              fetch_valid_q;
    logic              done_q;

    // fetch_valid/done are registered copies of (state==RUN)/(state==HALT),
    // updated alongside every state transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pc_q          <= '0;
            lut_idx_q     <= '0;
            fetch_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state         <= RUN;
                        pc_q          <= D'(START_PC);
                        fetch_valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        if (bus.halt) begin
                            state         <= HALT;
                            fetch_valid_q <= 1'b0;
                            done_q        <= 1'b1;
                        end else if (bus.br_req && bus.br_cond) begin
                            state         <= BRANCH;
                            lut_idx_q     <= bus.br_idx;
                            fetch_valid_q <= 1'b0;
                        end else begin
                            pc_q <= pc_q + D'(1);
                        end
                    end
                end
                BRANCH: begin
                    // lut_target already reflects lut_idx_q latched on entry
                    state         <= RUN;
                    pc_q          <= pc_q + bus.lut_target;
                    fetch_valid_q <= 1'b1;
                end
                HALT: begin
                    if (bus.start) begin
                        state         <= RUN;
                        pc_q          <= D'(START_PC);
                        fetch_valid_q <= 1'b1;
                        done_q        <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    fetch_valid_q <= 1'b0;
                    done_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.lut_idx     = lut_idx_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.done        = done_q;

`ifdef PC_SEQUENCER_PERF_EN
    logic run_active;
    logic perf_clr;
    logic taken_entry;

    assign run_active  = (state == RUN) && !bus.stall;
    assign taken_entry = run_active && !bus.halt && bus.br_req && bus.br_cond;
    assign perf_clr    = bus.start && ((state == IDLE) || (state == HALT));

    pcseq_sat_counter #(.W(32)) u_instr_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (perf_clr),
        .inc   (run_active),
        .count (instr_count)
    );

    pcseq_sat_counter #(.W(16)) u_taken_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (perf_clr),
        .inc   (taken_entry),
        .count (taken_count)
    );
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// Directed vector table with hand-derived expectations, a reset-during-BRANCH
// sequence, randomized traffic against a behavioural model, and (with
// PC_SEQUENCER_PERF_EN defined) performance counter checks.
module tb_pc_sequencer;

    localparam int PCW  = 12;
    localparam int AW   = 5;
    localparam int MODV = 4096;

    logic clk;
    logic reset;

    logic [PCW-1:0] lut_mem [32];

    pc_sequencer_if #(.D(PCW), .LUT_AW(AW)) bus ();

    assign bus.lut_target = lut_mem[bus.lut_idx];

`ifdef PC_SEQUENCER_PERF_EN
    logic [31:0] instr_count;
    logic [15:0] taken_count;
`endif

    pc_sequencer #(.D(PCW), .LUT_AW(AW), .START_PC(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PC_SEQUENCER_PERF_EN
        ,
        .instr_count (instr_count),
        .taken_count (taken_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_RUN, M_BRANCH, M_HALT} mmode_t;
    mmode_t m_mode;
    int     m_pc;
    int     m_idx;
    longint m_instr;
    longint m_taken;

    function automatic int signed_off(input logic [PCW-1:0] v);
        int u;
        u = int'(v);
        return (u >= MODV / 2) ? u - MODV : u;
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_pc    = 0;
        m_idx   = 0;
        m_instr = 0;
        m_taken = 0;
    endtask

    task automatic model_step(input logic st, input logic stl, input logic brq,
                              input logic brc, input int idx, input logic h);
        case (m_mode)
            M_IDLE, M_HALT: begin
                if (st) begin
                    m_mode  = M_RUN;
                    m_pc    = 0;
                    m_instr = 0;
                    m_taken = 0;
                end
            end
            M_RUN: begin
                if (!stl) begin
                    if (m_instr < 64'hFFFF_FFFF) m_instr++;
                    if (h) begin
                        m_mode = M_HALT;
                    end else if (brq && brc) begin
                        m_mode = M_BRANCH;
                        m_idx  = idx;
                        if (m_taken < 65535) m_taken++;
                    end else begin
                        m_pc = (m_pc + 1) % MODV;
                    end
                end
            end
            default: begin
                m_pc   = (m_pc + signed_off(lut_mem[m_idx]) + MODV) % MODV;
                m_mode = M_RUN;
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"}, longint'(bus.pc), m_pc);
        chk({tag, ".lut_idx"}, longint'(bus.lut_idx), m_idx);
        chk({tag, ".fetch_valid"}, longint'(bus.fetch_valid), (m_mode == M_RUN) ? 1 : 0);
        chk({tag, ".done"}, longint'(bus.done), (m_mode == M_HALT) ? 1 : 0);
`ifdef PC_SEQUENCER_PERF_EN
        chk({tag, ".instr_count"}, longint'(instr_count), m_instr);
        chk({tag, ".taken_count"}, longint'(taken_count), m_taken);
`endif
    endtask

    // Apply one cycle of inputs; the model follows along every cycle.
    task automatic step(input logic st, input logic stl, input logic brq,
                        input logic brc, input int idx, input logic h);
        bus.start   = st;
        bus.stall   = stl;
        bus.br_req  = brq;
        bus.br_cond = brc;
        bus.br_idx  = AW'(idx);
        bus.halt    = h;
        @(posedge clk);
        #1;
        model_step(st, stl, brq, brc, idx, h);
    endtask

    task automatic do_reset();
        bus.start   = 1'b0;
        bus.stall   = 1'b0;
        bus.br_req  = 1'b0;
        bus.br_cond = 1'b0;
        bus.br_idx  = '0;
        bus.halt    = 1'b0;
        reset       = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic st, stl, brq, brc;
        int   idx;
        logic h;
        int   e_pc;
        logic e_fv, e_done;
        int   e_idx;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic stl, input logic brq, input logic brc,
                       input int idx, input logic h,
                       input int e_pc, input logic e_fv, input logic e_done, input int e_idx);
        vec_t v;
        v = '{st, stl, brq, brc, idx, h, e_pc, e_fv, e_done, e_idx};
        vecs.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) lut_mem[i] = '0;
        lut_mem[2] = 12'd16;
        lut_mem[3] = 12'hFF6;   // -10

        reset = 1'b1;
        do_reset();
        chk("reset.pc", longint'(bus.pc), 0);
        chk("reset.lut_idx", longint'(bus.lut_idx), 0);
        chk("reset.fetch_valid", longint'(bus.fetch_valid), 0);
        chk("reset.done", longint'(bus.done), 0);

        //   st stl brq brc idx h   pc   fv d  idx
        add(1, 0, 0, 0, 0, 0,    0,  1, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 0, 0, 0, 0, 0, i, 1, 0, 0);
        add(0, 0, 1, 1, 3, 0,    5,  0, 0, 3);   // taken, offset -10
        add(0, 0, 0, 0, 0, 0, 4091,  1, 0, 3);
        for (int i = 4092; i <= 4095; i++) add(0, 0, 0, 0, 0, 0, i, 1, 0, 3);
        add(0, 0, 0, 0, 0, 0,    0,  1, 0, 3);   // wrap
        for (int i = 1; i <= 3; i++) add(0, 0, 0, 0, 0, 0, i, 1, 0, 3);
        add(0, 0, 1, 1, 2, 0,    3,  0, 0, 2);   // taken, offset 16
        add(1, 1, 0, 0, 0, 0,   19,  1, 0, 2);   // stall/start ignored in BRANCH
        add(0, 0, 1, 0, 9, 0,   20,  1, 0, 2);   // not taken
        add(0, 0, 0, 0, 0, 1,   20,  0, 1, 2);   // halt
        add(0, 0, 1, 1, 7, 0,   20,  0, 1, 2);   // ignored in HALT
        add(1, 0, 0, 0, 0, 0,    0,  1, 0, 2);   // restart
        for (int i = 1; i <= 3; i++) add(0, 0, 0, 0, 0, 0, i, 1, 0, 2);
        add(0, 0, 1, 0, 9, 0,    4,  1, 0, 2);   // not taken at pc=3
        for (int i = 5; i <= 7; i++) add(0, 0, 0, 0, 0, 0, i, 1, 0, 2);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 9, 0, 7, 1, 0, 2);  // stall
        add(0, 0, 1, 1, 5, 1,    7,  0, 1, 2);   // halt beats branch
        add(1, 0, 0, 0, 0, 0,    0,  1, 0, 2);
        add(1, 0, 0, 0, 0, 0,    1,  1, 0, 2);   // start in RUN ignored

        foreach (vecs[k]) begin
            step(vecs[k].st, vecs[k].stl, vecs[k].brq, vecs[k].brc, vecs[k].idx, vecs[k].h);
            chk($sformatf("vec%0d.pc", k), longint'(bus.pc), vecs[k].e_pc);
            chk($sformatf("vec%0d.fetch_valid", k), longint'(bus.fetch_valid), vecs[k].e_fv);
            chk($sformatf("vec%0d.done", k), longint'(bus.done), vecs[k].e_done);
            chk($sformatf("vec%0d.lut_idx", k), longint'(bus.lut_idx), vecs[k].e_idx);
        end

        // Reset in the middle of a BRANCH bubble takes effect without a clock.
        step(0, 0, 1, 1, 2, 0);
        chk("br_bubble.fetch_valid", longint'(bus.fetch_valid), 0);
        chk("br_bubble.lut_idx", longint'(bus.lut_idx), 2);
        reset = 1'b1;
        #1;
        chk("async_rst.pc", longint'(bus.pc), 0);
        chk("async_rst.fetch_valid", longint'(bus.fetch_valid), 0);
        chk("async_rst.done", longint'(bus.done), 0);
        chk("async_rst.lut_idx", longint'(bus.lut_idx), 0);
        #1;
        reset = 1'b0;
        model_reset();
        step(0, 0, 0, 0, 0, 0);
        check_model("post_rst_idle");

        // Randomized traffic against the model.
        for (int i = 0; i < 32; i++) lut_mem[i] = PCW'($urandom);
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) < 6),
                 ($urandom_range(0, 99) < 20),
                 ($urandom_range(0, 99) < 30),
                 ($urandom_range(0, 1) == 1),
                 int'($urandom_range(0, 31)),
                 ($urandom_range(0, 99) < 3));
            check_model($sformatf("rnd%0d", n));
        end

`ifdef PC_SEQUENCER_PERF_EN
        lut_mem[2] = 12'd16;
        do_reset();
        chk("perf_rst.instr_count", longint'(instr_count), 0);
        chk("perf_rst.taken_count", longint'(taken_count), 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 2, 0);
        step(0, 0, 0, 0, 0, 0);                 // bubble
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);                 // stalled, not counted
        step(0, 0, 1, 1, 2, 0);
        step(0, 0, 0, 0, 0, 0);                 // bubble
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0);
        chk("perf.instr_count", longint'(instr_count), 10);
        chk("perf.taken_count", longint'(taken_count), 2);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        chk("perf_clr.instr_count", longint'(instr_count), 0);
        chk("perf_clr.taken_count", longint'(taken_count), 0);
        check_model("perf_clr");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
